// File: rtl/avalon_mm_master_arbiter.sv
// Round-robin arbiter sharing one avalon_mm_master command port between NUM_REQ
// clients. Latches the winner's command, pulses m_start, waits for m_done (or a
// timeout), then returns a one-cycle ack (plus err on timeout) to the winner.
module avalon_mm_master_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_rnw,
    input  logic [4*NUM_REQ-1:0]    req_bytes,
    input  logic [32*NUM_REQ-1:0]   req_address,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    err,
    output logic [31:0]             rdata,
    output logic                    m_start,
    output logic                    m_rnw,
    output logic [3:0]              m_bytes,
    output logic [31:0]             m_address,
    output logic [31:0]             m_wdata,
    input  logic                    m_done,
    input  logic [31:0]             m_data_read
);

    localparam int unsigned IdxW        = (NUM_REQ > 2) ? 2 : 1;
    localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
    // Wraps harmlessly when the timeout is disabled; never compared in that case.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                m_start_q, m_start_d;
    logic                m_rnw_q, m_rnw_d;
    logic [3:0]          m_bytes_q, m_bytes_d;
    logic [31:0]         m_address_q, m_address_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     win_q, win_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [3:0]          bytes_arr [NUM_REQ];
    logic [31:0]         addr_arr  [NUM_REQ];
    logic [31:0]         wdata_arr [NUM_REQ];
    logic                found;
    logic [IdxW-1:0]     pick;
    logic [IdxW-1:0]     rr_idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign bytes_arr[i] = req_bytes[4*i +: 4];
        assign addr_arr[i]  = req_address[32*i +: 32];
        assign wdata_arr[i] = req_wdata[32*i +: 32];
    end

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = IdxW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        m_start_d   = 1'b0;
        m_rnw_d     = m_rnw_q;
        m_bytes_d   = m_bytes_q;
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d       = pick;
                    gnt_d       = NUM_REQ'(1) << pick;
                    m_rnw_d     = req_rnw[pick];
                    m_bytes_d   = bytes_arr[pick];
                    m_address_d = addr_arr[pick];
                    m_wdata_d   = wdata_arr[pick];
                    m_start_d   = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // The master may finish in the same cycle it sees start.
                if (m_done) begin
                    ack_d   = gnt_q;
                    rdata_d = m_rnw_q ? m_data_read : '0;
                    state_d = StDone;
                end else begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 16'd1;
                if (m_done) begin
                    ack_d   = gnt_q;
                    rdata_d = m_rnw_q ? m_data_read : '0;
                    state_d = StDone;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = '0;
                ptr_d   = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + IdxW'(1);
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            m_start_q   <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_bytes_q   <= '0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            m_start_q   <= m_start_d;
            m_rnw_q     <= m_rnw_d;
            m_bytes_q   <= m_bytes_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign m_start   = m_start_q;
    assign m_rnw     = m_rnw_q;
    assign m_bytes   = m_bytes_q;
    assign m_address = m_address_q;
    assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_avalon_mm_master_arbiter.sv
// Bench for avalon_mm_master_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_avalon_mm_master_arbiter;

    localparam int N     = 4;
    localparam int TO    = 8;
    localparam int NEVER = 255;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_rnw = '0;
    logic [4*N-1:0]  req_bytes = '0;
    logic [32*N-1:0] req_address = '0;
    logic [32*N-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, ack;
    logic            err;
    logic [31:0]     rdata;
    logic            m_start, m_rnw;
    logic [3:0]      m_bytes;
    logic [31:0]     m_address, m_wdata;
    logic            m_done = 1'b0;
    logic [31:0]     m_data_read = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;
    bit rand_mode = 1'b0;

    // Main-owned controls
    int          mdelay = 1;
    bit          fix_rd = 1'b0;
    logic [31:0] rd_fix = '0;
    logic        f_rnw   [N] = '{default: 1'b0};
    logic [3:0]  f_bytes [N] = '{default: 4'h0};
    logic [31:0] f_addr  [N] = '{default: 32'h0};
    logic [31:0] f_wdata [N] = '{default: 32'h0};
    int unsigned raise_cnt [N] = '{default: 0};
    int unsigned kill_cnt = 0;

    // Client-owned bookkeeping
    int unsigned raise_seen [N] = '{default: 0};
    int unsigned kill_seen = 0;
    int          mcnt = 0;

    always #5 CLK = ~CLK;

    avalon_mm_master_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req         (req),
        .req_rnw     (req_rnw),
        .req_bytes   (req_bytes),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .m_start     (m_start),
        .m_rnw       (m_rnw),
        .m_bytes     (m_bytes),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_done      (m_done),
        .m_data_read (m_data_read)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no event within bound, expected one (cycle %0d)", nm, cyc);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [N-1:0] e_gnt = '0, e_ack = '0;
    logic         e_err = 1'b0, e_start = 1'b0, e_rnw = 1'b0;
    logic [31:0]  e_rdata = '0, e_addr = '0, e_wdata = '0;
    logic [3:0]   e_bytes = '0;
    bit           busy = 1'b0, acked = 1'b0;
    int           win = 0, ptr = 0, issue_edge = 0;

    // Advance the model at every clock edge from the inputs present at that edge.
    always @(posedge CLK) begin
        logic [1:0] ix;
        bit         got;
        cyc++;
        if (RESET) begin
            busy = 0; acked = 0; ptr = 0;
            e_gnt = '0; e_ack = '0; e_err = 0; e_rdata = '0; e_start = 0;
            e_rnw = 0; e_bytes = '0; e_addr = '0; e_wdata = '0;
        end else begin
            e_start = 1'b0;
            if (busy && acked) begin
                // cycle after the ack: release and advance the pointer
                e_ack = '0; e_err = 1'b0; e_gnt = '0;
                ptr = (win + 1) % N;
                busy = 0; acked = 0;
            end else if (busy) begin
                if (m_done === 1'b1) begin
                    acked = 1; e_ack = e_gnt; e_err = 1'b0;
                    e_rdata = e_rnw ? m_data_read : 32'h0;
                end else if (TO != 0 && (cyc - issue_edge) == TO + 1) begin
                    // ISSUE cycle plus TO busy cycles have elapsed
                    acked = 1; e_ack = e_gnt; e_err = 1'b1; e_rdata = 32'h0;
                end
            end else if (req != '0) begin
                got = 0;
                for (int j = 0; j < N; j++) begin
                    ix = 2'((ptr + j) % N);
                    if (!got && req[ix]) begin
                        got = 1;
                        win = (ptr + j) % N;
                    end
                end
                ix = 2'(win);
                e_gnt   = 4'(1 << win);
                e_rnw   = req_rnw[ix];
                e_bytes = req_bytes[4*win +: 4];
                e_addr  = req_address[32*win +: 32];
                e_wdata = req_wdata[32*win +: 32];
                e_start = 1'b1;
                busy = 1; acked = 0; issue_edge = cyc;
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge CLK) begin
        if (chk_on) begin
            chk("gnt",     32'(gnt),   32'(e_gnt));
            chk("ack",     32'(ack),   32'(e_ack));
            chk("err",     32'(err),   32'(e_err));
            chk("rdata",   rdata,      e_rdata);
            chk("m_start", 32'(m_start), 32'(e_start));
            chk("m_rnw",   32'(m_rnw), 32'(e_rnw));
            chk("m_bytes", 32'(m_bytes), 32'(e_bytes));
            chk("m_addr",  m_address,  e_addr);
            chk("m_wdata", m_wdata,    e_wdata);
        end
    end

    // ---------------- master model ----------------
    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return r;
        if (r == 6) return TO;
        if (r == 7) return NEVER;
        return int'($urandom_range(1, 3));
    endfunction

    always @(negedge CLK) begin
        int d;
        m_data_read = fix_rd ? rd_fix : $urandom;
        m_done = 1'b0;
        if (RESET) begin
            mcnt = 0;
        end else begin
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) m_done = 1'b1;
            end
            if (m_start === 1'b1) begin
                d = rand_mode ? pick_delay() : mdelay;
                if (d == 0) m_done = 1'b1;
                else if (d != NEVER) mcnt = d;
            end
        end
    end

    // ---------------- client model ----------------
    always @(negedge CLK) begin
        logic [1:0] ci;
        if (kill_cnt != kill_seen) begin
            kill_seen = kill_cnt;
            req = '0;
        end
        for (int i = 0; i < N; i++) begin
            ci = 2'(i);
            if (ack[ci] === 1'b1) begin
                req[ci] = 1'b0;
            end else if (!req[ci]) begin
                if (raise_cnt[i] != raise_seen[i]) begin
                    raise_seen[i] = raise_cnt[i];
                    req_rnw[ci] = f_rnw[i];
                    req_bytes[4*i +: 4] = f_bytes[i];
                    req_address[32*i +: 32] = f_addr[i];
                    req_wdata[32*i +: 32] = f_wdata[i];
                    req[ci] = 1'b1;
                end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                    req_rnw[ci] = 1'($urandom);
                    req_bytes[4*i +: 4] = 4'($urandom);
                    req_address[32*i +: 32] = $urandom;
                    req_wdata[32*i +: 32] = $urandom;
                    req[ci] = 1'b1;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic raise(input int i, input logic rnw, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] w);
        f_rnw[i] = rnw; f_bytes[i] = b; f_addr[i] = a; f_wdata[i] = w;
        raise_cnt[i]++;
    endtask

    task automatic wait_start(output int c);
        bit seen = 0;
        c = -100;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge CLK);
            if (m_start === 1'b1) begin seen = 1; c = cyc; end
        end
        if (!seen) timeout_fail("wait_start");
    endtask

    task automatic wait_ack(output int c);
        bit seen = 0;
        c = -100;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge CLK);
            if (ack !== '0) begin seen = 1; c = cyc; end
        end
        if (!seen) timeout_fail("wait_ack");
    endtask

    task automatic settle();
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int s, a;
        repeat (3) @(negedge CLK);
        chk_on = 1'b1;
        RESET = 1'b0;
        chk("rst_gnt",    32'(gnt), 32'h0);
        chk("rst_mstart", 32'(m_start), 32'h0);
        chk("rst_maddr",  m_address, 32'h0);

        // single write, done 3 cycles after start
        mdelay = 3;
        raise(1, 1'b0, 4'hF, 32'h1000_0040, 32'hDEAD_BEEF);
        wait_start(s);
        chk("w_gnt",   32'(gnt), 32'h2);
        chk("w_addr",  m_address, 32'h1000_0040);
        chk("w_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("w_bytes", 32'(m_bytes), 32'hF);
        @(negedge CLK);
        chk("w_pulse", 32'(m_start), 32'h0);
        wait_ack(a);
        chk("w_ack", 32'(ack), 32'h2);
        chk("w_err", 32'(err), 32'h0);
        chk("w_lat", 32'(a - s), 32'd4);
        settle();

        // read capture
        fix_rd = 1'b1; rd_fix = 32'h1234_5678; mdelay = 2;
        raise(0, 1'b1, 4'h3, 32'h2000_0000, 32'h0);
        wait_ack(a);
        chk("r_ack",   32'(ack), 32'h1);
        chk("r_rdata", rdata, 32'h1234_5678);
        fix_rd = 1'b0;
        settle();

        // round robin from a freshly reset pointer
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        mdelay = 1;
        for (int i = 0; i < N; i++) raise(i, 1'b0, 4'hF, 32'h100 * i, 32'h55 + i);
        for (int k = 0; k < N; k++) begin
            wait_ack(a);
            chk($sformatf("rr_order%0d", k), 32'(ack), 32'(1 << k));
        end
        settle();
        raise(0, 1'b0, 4'h1, 32'h40, 32'h1);
        raise(3, 1'b0, 4'h8, 32'h4C, 32'h3);
        wait_ack(a);
        chk("rr_1001_first", 32'(ack), 32'h1);
        wait_ack(a);
        chk("rr_1001_next", 32'(ack), 32'h8);
        settle();

        // timeout: master never answers
        mdelay = NEVER;
        raise(2, 1'b1, 4'hF, 32'h3000_0000, 32'h0);
        wait_start(s);
        wait_ack(a);
        chk("to_ack",   32'(ack), 32'h4);
        chk("to_err",   32'(err), 32'h1);
        chk("to_rdata", rdata, 32'h0);
        chk("to_lat",   32'(a - s), 32'(TO + 1));
        settle();
        mdelay = 2;
        raise(2, 1'b0, 4'hF, 32'h3000_0004, 32'h9);
        wait_ack(a);
        chk("to_next_ack", 32'(ack), 32'h4);
        chk("to_next_err", 32'(err), 32'h0);
        settle();

        // reset while busy: no ack, outputs cleared, pointer back to 0
        mdelay = NEVER;
        raise(1, 1'b0, 4'hF, 32'h7777_0000, 32'h1111_2222);
        wait_start(s);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        kill_cnt++;
        @(negedge CLK);
        RESET = 1'b0;
        chk("mr_gnt",   32'(gnt), 32'h0);
        chk("mr_ack",   32'(ack), 32'h0);
        chk("mr_addr",  m_address, 32'h0);
        chk("mr_wdata", m_wdata, 32'h0);
        settle();
        mdelay = 1;
        raise(3, 1'b0, 4'hF, 32'h30, 32'h3);
        raise(0, 1'b0, 4'hF, 32'h00, 32'h0);
        wait_ack(a);
        chk("mr_first", 32'(ack), 32'h1);
        wait_ack(a);
        chk("mr_second", 32'(ack), 32'h8);
        settle();

        // m_done on the same cycle the timeout would fire
        fix_rd = 1'b1; rd_fix = 32'hCAFE_F00D; mdelay = TO;
        raise(1, 1'b1, 4'hF, 32'h50, 32'h0);
        wait_start(s);
        wait_ack(a);
        chk("tie_err",   32'(err), 32'h0);
        chk("tie_rdata", rdata, 32'hCAFE_F00D);
        chk("tie_lat",   32'(a - s), 32'(TO + 1));
        settle();

        // m_done during ISSUE
        rd_fix = 32'h0BAD_F00D; mdelay = 0;
        raise(2, 1'b1, 4'hF, 32'h60, 32'h0);
        wait_start(s);
        wait_ack(a);
        chk("iss_lat",   32'(a - s), 32'd1);
        chk("iss_rdata", rdata, 32'h0BAD_F00D);
        fix_rd = 1'b0;
        settle();

        // random traffic with occasional resets
        rand_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLK);
            RESET = ($urandom_range(0, 299) == 0);
        end
        RESET = 1'b0;
        rand_mode = 1'b0;
        mdelay = 1;
        repeat (60) @(negedge CLK);
        chk("quiesce_gnt", 32'(gnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
